branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, number of cycles Flush stays asserted after a mispredicted branch transfers.
REQ-002 Parameter CNT_W, default 16, width of the statistics counters.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 InValid  in  1  upstream holds a valid branch record.
REQ-006 InReady  out  1  stage accepts the record this cycle.
REQ-007 BrOp  in  3  branch operation: NONE=0, BEQ=1, BNE=2, BLT=3, BGE=4, BLE=5, BGT=6, JMP=7.
REQ-008 NotEqual  in  1  comparator flag, A!=B for the record's operands.
REQ-009 LessThan  in  1  comparator flag, signed A<B for the record's operands.
REQ-010 PC  in  32  address of the branch instruction.
REQ-011 Offset  in  32  sign-extended word offset.
REQ-012 PredTaken  in  1  front-end prediction for this branch.
REQ-013 OutValid  out  1  resolved record is available.
REQ-014 OutReady  in  1  downstream accepts the resolved record.
REQ-015 Taken  out  1  resolved direction.
REQ-016 Target  out  32  resolved next PC.
REQ-017 Mispredict  out  1  Taken differs from PredTaken.
REQ-018 Flush  out  1  squash younger instructions and redirect fetch to Target.
REQ-019 BranchCnt  out  CNT_W  count of transferred records with BrOp!=NONE.
REQ-020 MispredCnt  out  CNT_W  count of transferred records with Mispredict=1.

Function
REQ-021 Taken SHALL be: NONE 0; BEQ !NotEqual; BNE NotEqual; BLT LessThan; BGE !LessThan; BLE LessThan|!NotEqual; BGT !LessThan&NotEqual; JMP 1.
REQ-022 Target SHALL be PC+4+(Offset<<2) if Taken, else PC+4, modulo 2^32; wrap past 0xFFFFFFFC is silent.
REQ-023 Mispredict SHALL be Taken XOR PredTaken, forced to 0 when BrOp=NONE.
REQ-024 Latency SHALL be one cycle: a record accepted in cycle N (InValid&InReady) drives OutValid and its results in cycle N+1.
REQ-025 While OutValid=1 and OutReady=0, all outputs SHALL hold stable.
REQ-026 InReady SHALL be 1 only in state RUN and only when (OutValid=0 or OutReady=1) and not (OutValid=1 and Mispredict=1).
REQ-027 The state machine SHALL have two states. RUN -> FLUSH on transfer (OutValid&OutReady) of a record with Mispredict=1. FLUSH -> RUN after exactly FLUSH_CYCLES cycles.
REQ-028 Flush SHALL be 1 in every FLUSH cycle and 0 otherwise; Target SHALL hold the mispredicted record's value throughout FLUSH.
REQ-029 In FLUSH, OutValid SHALL be 0, InReady SHALL be 0, and InValid SHALL be ignored.
REQ-030 Counters SHALL increment only on output transfer, SHALL saturate at all-ones, and SHALL never wrap.
REQ-031 Transfer out and acceptance in the same cycle SHALL be legal for a correctly predicted record (full throughput).

Reset
REQ-032 Asserting rst_n=0 SHALL immediately force state RUN, OutValid=0, Flush=0, Taken=0, Mispredict=0, Target=0, BranchCnt=0, MispredCnt=0.
REQ-033 Reset asserted mid-FLUSH or with a held output SHALL discard that record with no further Flush.
REQ-034 InReady SHALL be 1 in the first cycle after release.

Structure
REQ-035 BrOp encodings, the state enumeration, and the PC increment constant 4 SHALL reside in shared package br_pkg.
REQ-036 The REQ-021 condition decode SHALL be a combinational sub-module, branch_cond.

Verification
REQ-037 BEQ, NotEqual=0, PC=0x100, Offset=3, PredTaken=1 -> next cycle OutValid=1, Taken=1, Target=0x110, Mispredict=0, Flush never asserted.
REQ-038 BLT, LessThan=0, PC=0x200, PredTaken=1 -> Taken=0, Target=0x204, Mispredict=1. After transfer: Flush=1 for exactly 2 cycles, InReady=0 throughout, MispredCnt=1.
REQ-039 Back-to-back correct BNE records with OutReady=1 -> one accept per cycle, BranchCnt=N after N transfers.
REQ-040 OutReady=0 for 5 cycles with a result held -> outputs stable and InReady=0; on release, exactly one transfer.
REQ-041 JMP, PC=0xFFFFFFF8, Offset=1 -> Target=0x00000000 (wrap).
REQ-042 rst_n=0 asserted in FLUSH cycle 1 -> Flush=0 immediately, counters=0, InReady=1 after release.

Source files
------------

// File: rtl/br_pkg.sv
// Shared branch-resolve types: op encodings, FSM states, result bundle.
// Used by branch_cond and branch_resolve.
package br_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BLE  = 3'd5,
    BR_BGT  = 3'd6,
    BR_JMP  = 3'd7
  } br_op_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } br_state_e;

  localparam logic [31:0] PC_INC = 32'd4;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic        mispred;
    logic        is_br;
  } br_res_t;

  function automatic logic [31:0] br_target(
    input logic [31:0] pc,
    input logic [31:0] off,
    input logic        taken
  );
    logic [31:0] seq;
    seq = pc + PC_INC;
    return taken ? seq + {off[29:0], 2'b00} : seq;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition decode from comparator flags.
// Ports: op (branch op), ne (A!=B), lt (signed A<B), taken.
module branch_cond
  import br_pkg::*;
(
  input  br_op_e op,
  input  logic   ne,
  input  logic   lt,
  output logic   taken
);

  always_comb begin
    taken = 1'b0;
    unique case (op)
      BR_NONE: taken = 1'b0;
      BR_BEQ:  taken = !ne;
      BR_BNE:  taken = ne;
      BR_BLT:  taken = lt;
      BR_BGE:  taken = !lt;
      BR_BLE:  taken = lt | !ne;
      BR_BGT:  taken = !lt & ne;
      BR_JMP:  taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolve stage: 1-cycle resolve, valid/ready out, flush FSM,
// saturating branch/mispredict statistics.
module branch_resolve
  import br_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [2:0]       BrOp,
  input  logic             NotEqual,
  input  logic             LessThan,
  input  logic [31:0]      PC,
  input  logic [31:0]      Offset,
  input  logic             PredTaken,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             Taken,
  output logic [31:0]      Target,
  output logic             Mispredict,
  output logic             Flush,
  output logic [CNT_W-1:0] BranchCnt,
  output logic [CNT_W-1:0] MispredCnt
);

  localparam int FW =
    (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FL_LAST = FW'(FLUSH_CYCLES - 1);

  br_op_e      op;
  logic        cond_taken;
  br_res_t     res;
  br_state_e   state;
  logic [FW-1:0] fl_cnt;
  logic        is_br_q;
  logic        accept;
  logic        xfer;

  assign op = br_op_e'(BrOp);

  branch_cond u_cond (
    .op    (op),
    .ne    (NotEqual),
    .lt    (LessThan),
    .taken (cond_taken)
  );

  always_comb begin
    res.taken   = cond_taken;
    res.target  = br_target(PC, Offset, cond_taken);
    res.is_br   = (op != BR_NONE);
    res.mispred = res.is_br & (cond_taken ^ PredTaken);
  end

  // a held mispredict must leave before anything younger enters
  assign InReady = (state == ST_RUN)
                 && (!OutValid || OutReady)
                 && !(OutValid && Mispredict);
  assign accept = InValid && InReady;
  assign xfer   = OutValid && OutReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      OutValid   <= 1'b0;
      Flush      <= 1'b0;
      Taken      <= 1'b0;
      Mispredict <= 1'b0;
      Target     <= '0;
      is_br_q    <= 1'b0;
      BranchCnt  <= '0;
      MispredCnt <= '0;
      fl_cnt     <= '0;
    end else begin
      if (xfer) begin
        if (is_br_q && BranchCnt != '1)
          BranchCnt <= BranchCnt + 1'b1;
        if (Mispredict && MispredCnt != '1)
          MispredCnt <= MispredCnt + 1'b1;
      end
      unique case (state)
        ST_RUN: begin
          if (accept) begin
            OutValid   <= 1'b1;
            Taken      <= res.taken;
            Target     <= res.target;
            Mispredict <= res.mispred;
            is_br_q    <= res.is_br;
          end else if (xfer) begin
            OutValid <= 1'b0;
          end
          if (xfer && Mispredict) begin
            state  <= ST_FLUSH;
            Flush  <= 1'b1;
            fl_cnt <= FL_LAST;
          end
        end
        ST_FLUSH: begin
          if (fl_cnt == '0) begin
            state <= ST_RUN;
            Flush <= 1'b0;
          end else begin
            fl_cnt <= fl_cnt - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed + random bench for branch_resolve with a result scoreboard.
// Inputs driven on negedge; outputs compared before the next posedge.
module tb_branch_resolve;
  import br_pkg::*;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [2:0]    BrOp = 3'd0;
  logic          NotEqual = 1'b0;
  logic          LessThan = 1'b0;
  logic [31:0]   PC = '0;
  logic [31:0]   Offset = '0;
  logic          PredTaken = 1'b0;
  logic          OutValid;
  logic          OutReady = 1'b0;
  logic          Taken;
  logic [31:0]   Target;
  logic          Mispredict;
  logic          Flush;
  logic [CW-1:0] BranchCnt;
  logic [CW-1:0] MispredCnt;

  typedef struct {
    logic        tk;
    logic [31:0] tg;
    logic        mp;
    logic        br;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail = 0;
  int exp_br = 0;
  int exp_mp = 0;

  branch_resolve #(.FLUSH_CYCLES(2), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .InValid    (InValid),
    .InReady    (InReady),
    .BrOp       (BrOp),
    .NotEqual   (NotEqual),
    .LessThan   (LessThan),
    .PC         (PC),
    .Offset     (Offset),
    .PredTaken  (PredTaken),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .Taken      (Taken),
    .Target     (Target),
    .Mispredict (Mispredict),
    .Flush      (Flush),
    .BranchCnt  (BranchCnt),
    .MispredCnt (MispredCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_tk(input br_op_e op, input int a,
                                  input int b);
    case (op)
      BR_BEQ:  return a == b;
      BR_BNE:  return a != b;
      BR_BLT:  return a < b;
      BR_BGE:  return a >= b;
      BR_BLE:  return a <= b;
      BR_BGT:  return a > b;
      BR_JMP:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // one clock: drive, check transfer, record acceptance, wait
  task automatic cyc(input logic v, input br_op_e op, input int a,
                     input int b, input logic [31:0] pc,
                     input logic [31:0] off, input logic pred,
                     input logic ordy, input int er);
    exp_t e;
    InValid   = v;
    BrOp      = op;
    NotEqual  = (a != b);
    LessThan  = (a < b);
    PC        = pc;
    Offset    = off;
    PredTaken = pred;
    OutReady  = ordy;
    #1;
    if (er >= 0) chk("in_ready", {31'd0, InReady}, er);
    if (OutValid && OutReady) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("taken", {31'd0, Taken}, {31'd0, e.tk});
        chk("target", Target, e.tg);
        chk("mispredict", {31'd0, Mispredict}, {31'd0, e.mp});
        if (e.br) exp_br++;
        if (e.mp) exp_mp++;
      end
    end
    if (InValid && InReady) begin
      e.tk = exp_tk(op, a, b);
      e.tg = e.tk ? pc + 32'd4 + (off << 2) : pc + 32'd4;
      e.br = (op != BR_NONE);
      e.mp = e.br && (e.tk != pred);
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  initial begin
    int a;
    int b;
    int o;
    br_op_e op;
    exp_t h;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, OutValid}, 0);
    chk("rst_flush", {31'd0, Flush}, 0);
    chk("rst_taken", {31'd0, Taken}, 0);
    chk("rst_mispred", {31'd0, Mispredict}, 0);
    chk("rst_target", Target, 0);
    chk("rst_branch_cnt", 32'(BranchCnt), 0);
    chk("rst_mispred_cnt", 32'(MispredCnt), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // BEQ taken, predicted taken
    cyc(1, BR_BEQ, 5, 5, 32'h100, 32'd3, 1, 1, 1);
    chk("beq_flush0", {31'd0, Flush}, 0);
    cyc(0, BR_NONE, 0, 0, 0, 0, 0, 1, 1);
    chk("beq_flush1", {31'd0, Flush}, 0);
    chk("beq_branch_cnt", 32'(BranchCnt), exp_br);

    // back-to-back correct BNE
    for (int i = 0; i < 4; i++)
      cyc(1, BR_BNE, 1, 2, 32'h300 + 32'(i * 4), 32'd8, 1, 1, 1);
    cyc(0, BR_NONE, 0, 0, 0, 0, 0, 1, 1);
    chk("bne_branch_cnt", 32'(BranchCnt), 5);

    // backpressure hold for 5 cycles
    cyc(1, BR_BEQ, 1, 2, 32'h400, 32'd5, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      h = sb[0];
      chk("hold_valid", {31'd0, OutValid}, 1);
      chk("hold_taken", {31'd0, Taken}, {31'd0, h.tk});
      chk("hold_target", Target, h.tg);
      chk("hold_mispred", {31'd0, Mispredict}, {31'd0, h.mp});
      cyc(1, BR_BGE, 4, 2, 32'h500, 32'd1, 1, 0, 0);
    end
    cyc(1, BR_BGE, 4, 2, 32'h500, 32'd1, 1, 1, 1);
    cyc(0, BR_NONE, 0, 0, 0, 0, 0, 1, 1);
    chk("hold_drained", {31'd0, OutValid}, 0);
    chk("hold_branch_cnt", 32'(BranchCnt), exp_br);

    // JMP wrap past the top of the address space
    cyc(1, BR_JMP, 0, 0, 32'hFFFF_FFF8, 32'd1, 1, 1, 1);
    cyc(0, BR_NONE, 0, 0, 0, 0, 0, 1, 1);

    // random correctly predicted mix at full throughput
    for (int i = 0; i < 16; i++) begin
      op = br_op_e'($urandom_range(0, 7));
      a = int'($urandom_range(0, 4)) - 2;
      b = int'($urandom_range(0, 4)) - 2;
      o = int'($urandom_range(0, 255)) - 128;
      cyc(1, op, a, b, $urandom, 32'(o), exp_tk(op, a, b), 1, 1);
    end
    cyc(0, BR_NONE, 0, 0, 0, 0, 0, 1, 1);
    chk("mix_branch_cnt", 32'(BranchCnt), exp_br);
    chk("mix_mispred_cnt", 32'(MispredCnt), 0);

    // BLT mispredict -> 2 flush cycles
    cyc(1, BR_BLT, 3, 1, 32'h200, 32'd7, 1, 1, 1);
    cyc(0, BR_NONE, 0, 0, 0, 0, 0, 1, 0);
    chk("fl1_flush", {31'd0, Flush}, 1);
    chk("fl1_out_valid", {31'd0, OutValid}, 0);
    chk("fl1_target", Target, 32'h204);
    cyc(1, BR_BEQ, 0, 0, 32'h600, 32'd1, 1, 1, 0);
    chk("fl2_flush", {31'd0, Flush}, 1);
    chk("fl2_target", Target, 32'h204);
    cyc(1, BR_BEQ, 0, 0, 32'h600, 32'd1, 1, 1, 0);
    chk("fl_end_flush", {31'd0, Flush}, 0);
    chk("fl_mispred_cnt", 32'(MispredCnt), 1);
    cyc(0, BR_NONE, 0, 0, 0, 0, 0, 1, 1);
    chk("fl_ignored_in", {31'd0, OutValid}, 0);

    // reset in flush cycle 1
    cyc(1, BR_BGT, 1, 1, 32'h700, 32'd2, 1, 1, 1);
    cyc(0, BR_NONE, 0, 0, 0, 0, 0, 1, 0);
    chk("rf_flush_before", {31'd0, Flush}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rf_flush", {31'd0, Flush}, 0);
    chk("rf_out_valid", {31'd0, OutValid}, 0);
    chk("rf_target", Target, 0);
    chk("rf_branch_cnt", 32'(BranchCnt), 0);
    chk("rf_mispred_cnt", 32'(MispredCnt), 0);
    sb.delete();
    exp_br = 0;
    exp_mp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, BR_BNE, 0, 3, 32'h800, 32'd4, 1, 1, 1);
    chk("rf_no_flush", {31'd0, Flush}, 0);
    cyc(0, BR_NONE, 0, 0, 0, 0, 0, 1, 1);
    chk("rf_branch_cnt_after", 32'(BranchCnt), 1);
    chk("sb_empty_end", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
